zzlab_env_regs: RTL and testbench

- Parametrised AXI4-Lite control/status register slave; next generation of the environment-identification control block.
- Sits at the top of the zzlab_env hierarchy on s_axi_control.
- Provides ID/capability registers, NUM_SCRATCH byte-strobed scratch registers, and an NUM_IRQ-bit interrupt controller with W1C status and a registered interrupt output.
- Decodes unmapped addresses with SLVERR.

---
 rtl/zzlab_env_pkg.sv | 29 ++
 rtl/zzlab_env_irq_ctrl.sv | 49 ++++
 rtl/zzlab_env_regs.sv | 233 +++++++++++++++++++++++
 tb/tb_zzlab_env_regs.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zzlab_env_pkg.sv
// Shared constants for the zzlab_env control/status register slave: register
// offsets, AXI responses and FSM state encodings.
package zzlab_env_pkg;

    localparam int OFF_VERSION       = 'h00;
    localparam int OFF_PLATFORM      = 'h04;
    localparam int OFF_BOARD_VERSION = 'h08;
    localparam int OFF_CAPS          = 'h0C;
    localparam int OFF_IRQ_STATUS    = 'h10;
    localparam int OFF_IRQ_ENABLE    = 'h14;
    localparam int OFF_UPTIME_LO     = 'h18;
    localparam int OFF_UPTIME_HI     = 'h1C;
    localparam int OFF_SCRATCH0      = 'h20;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] WRIDLE = 2'd0;
    localparam logic [1:0] WRDATA = 2'd1;
    localparam logic [1:0] WRRESP = 2'd2;

    localparam logic [0:0] RDIDLE = 1'b0;
    localparam logic [0:0] RDDATA = 1'b1;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/zzlab_env_irq_ctrl.sv
// Interrupt controller: level-sampled sources into a W1C status register,
// strobed enable register, and a registered interrupt output.
module zzlab_env_irq_ctrl
    import zzlab_env_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    input  logic [NUM_IRQ-1:0] w1c_mask_i,
    input  logic               en_we_i,
    input  logic [NUM_IRQ-1:0] en_mask_i,
    input  logic [NUM_IRQ-1:0] en_data_i,
    output logic [NUM_IRQ-1:0] status_o,
    output logic [NUM_IRQ-1:0] enable_o,
    output logic               irq_o
);

    logic [NUM_IRQ-1:0] status_q, status_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic               irq_q;

    // A new event on a source beats a simultaneous clear of the same bit.
    always_comb begin
        status_d = (status_q & ~w1c_mask_i) | irq_src_i;
        enable_d = enable_q;
        if (en_we_i) begin
            enable_d = (enable_q & ~en_mask_i) | (en_data_i & en_mask_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            status_q <= '0;
            enable_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            enable_q <= enable_d;
            irq_q    <= |(status_q & enable_q);
        end
    end

    assign status_o = status_q;
    assign enable_o = enable_q;
    assign irq_o    = irq_q;

endmodule

// File: rtl/zzlab_env_regs.sv
// AXI4-Lite control/status register slave for the zzlab_env hierarchy.
// Optional 64-bit uptime counter built only when ZZLAB_ENV_UPTIME_EN is defined.
//
// state  | meaning
// WRIDLE | waiting for write address (AWREADY)
// WRDATA | address latched, waiting for write data (WREADY)
// WRRESP | write done, holding BVALID until BREADY
// RDIDLE | waiting for read address (ARREADY)
// RDDATA | read data registered, holding RVALID until RREADY
module zzlab_env_regs
    import zzlab_env_pkg::*;
#(
    parameter int          C_S_AXI_ADDR_WIDTH = 8,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter logic [31:0] C_VERSION          = 32'h25020401,
    parameter logic [31:0] C_PLATFORM         = "VPRO",
    parameter logic [31:0] C_BOARD_VERSION    = 32'h00020101,
    parameter int          NUM_SCRATCH        = 4,
    parameter int          NUM_IRQ            = 8
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  logic                            s_axi_control_AWVALID,
    output logic                            s_axi_control_AWREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_AWADDR,
    input  logic                            s_axi_control_WVALID,
    output logic                            s_axi_control_WREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_control_WSTRB,
    output logic                            s_axi_control_BVALID,
    input  logic                            s_axi_control_BREADY,
    output logic [1:0]                      s_axi_control_BRESP,
    input  logic                            s_axi_control_ARVALID,
    output logic                            s_axi_control_ARREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_ARADDR,
    output logic                            s_axi_control_RVALID,
    input  logic                            s_axi_control_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_RDATA,
    output logic [1:0]                      s_axi_control_RRESP,
    input  logic [NUM_IRQ-1:0]              irq_src,
    output logic                            interrupt
);

    localparam int IDXW = C_S_AXI_ADDR_WIDTH - 2;

`ifdef ZZLAB_ENV_UPTIME_EN
    localparam logic UPTIME_CAP = 1'b1;
`else
    localparam logic UPTIME_CAP = 1'b0;
`endif
    localparam logic [31:0] CAPS_VAL = {UPTIME_CAP, 20'd0, 6'(NUM_IRQ), 5'(NUM_SCRATCH)};

    function automatic logic [IDXW-1:0] word_idx(input int off);
        return IDXW'(off >> 2);
    endfunction

    logic            rst_done_q;
    logic [1:0]      wstate_q, wstate_d;
    logic [IDXW-1:0] widx_q;
    logic [1:0]      bresp_q;
    logic [0:0]      rstate_q, rstate_d;
    logic [31:0]     rdata_q;
    logic [1:0]      rresp_q;
    logic [31:0]     scratch_q [NUM_SCRATCH];

    logic [IDXW-1:0]    ridx;
    logic               aw_fire, w_fire, ar_fire;
    logic [31:0]        wmask, wbits;
    logic               wr_hit, rd_hit;
    logic [31:0]        rd_data;
    logic [NUM_IRQ-1:0] irq_status, irq_enable, w1c_mask;
    logic               en_we;
    logic [31:0]        status32, enable32;
    logic               unused_addr_lsbs;

    assign unused_addr_lsbs = ^{s_axi_control_AWADDR[1:0], s_axi_control_ARADDR[1:0]};

    // Readies stay low until the first clock after reset release.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) rst_done_q <= 1'b0;
        else           rst_done_q <= 1'b1;
    end

    assign s_axi_control_AWREADY = rst_done_q & (wstate_q == WRIDLE);
    assign s_axi_control_WREADY  = (wstate_q == WRDATA);
    assign s_axi_control_BVALID  = (wstate_q == WRRESP);
    assign s_axi_control_BRESP   = bresp_q;
    assign s_axi_control_ARREADY = rst_done_q & (rstate_q == RDIDLE);
    assign s_axi_control_RVALID  = (rstate_q == RDDATA);
    assign s_axi_control_RDATA   = rdata_q;
    assign s_axi_control_RRESP   = rresp_q;

    assign aw_fire = s_axi_control_AWVALID & s_axi_control_AWREADY;
    assign w_fire  = s_axi_control_WVALID & s_axi_control_WREADY;
    assign ar_fire = s_axi_control_ARVALID & s_axi_control_ARREADY;
    assign ridx    = s_axi_control_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wmask   = strb_to_mask(s_axi_control_WSTRB);
    assign wbits   = s_axi_control_WDATA & wmask;

    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            WRIDLE:  if (aw_fire) wstate_d = WRDATA;
            WRDATA:  if (s_axi_control_WVALID) wstate_d = WRRESP;
            WRRESP:  if (s_axi_control_BREADY) wstate_d = WRIDLE;
            default: wstate_d = WRIDLE;
        endcase
    end

    // RO registers count as mapped: writes to them are dropped but answer OKAY.
    always_comb begin
        wr_hit = (widx_q <= word_idx(OFF_IRQ_ENABLE));
`ifdef ZZLAB_ENV_UPTIME_EN
        if (widx_q == word_idx(OFF_UPTIME_LO) || widx_q == word_idx(OFF_UPTIME_HI)) wr_hit = 1'b1;
`endif
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (widx_q == word_idx(OFF_SCRATCH0 + 4 * i)) wr_hit = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wstate_q <= WRIDLE;
            widx_q   <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            wstate_q <= wstate_d;
            if (aw_fire) widx_q <= s_axi_control_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            if (w_fire)  bresp_q <= wr_hit ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
        end else if (w_fire) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (widx_q == word_idx(OFF_SCRATCH0 + 4 * i)) begin
                    scratch_q[i] <= (scratch_q[i] & ~wmask) | wbits;
                end
            end
        end
    end

    assign w1c_mask = (w_fire && widx_q == word_idx(OFF_IRQ_STATUS)) ? wbits[NUM_IRQ-1:0] : '0;
    assign en_we    = w_fire && (widx_q == word_idx(OFF_IRQ_ENABLE));

    zzlab_env_irq_ctrl #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq (
        .clk_i      (ap_clk),
        .rst_n_i    (ap_rst_n),
        .irq_src_i  (irq_src),
        .w1c_mask_i (w1c_mask),
        .en_we_i    (en_we),
        .en_mask_i  (wmask[NUM_IRQ-1:0]),
        .en_data_i  (s_axi_control_WDATA[NUM_IRQ-1:0]),
        .status_o   (irq_status),
        .enable_o   (irq_enable),
        .irq_o      (interrupt)
    );

`ifdef ZZLAB_ENV_UPTIME_EN
    logic [63:0] uptime_q;
    logic [31:0] uptime_hi_q;

    // HI is a shadow captured by the LO read so a LO/HI pair is coherent.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            uptime_q    <= '0;
            uptime_hi_q <= '0;
        end else begin
            uptime_q <= uptime_q + 64'd1;
            if (ar_fire && ridx == word_idx(OFF_UPTIME_LO)) uptime_hi_q <= uptime_q[63:32];
        end
    end
`endif

    always_comb begin
        status32 = '0;
        enable32 = '0;
        status32[NUM_IRQ-1:0] = irq_status;
        enable32[NUM_IRQ-1:0] = irq_enable;
    end

    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b1;
        if      (ridx == word_idx(OFF_VERSION))       rd_data = C_VERSION;
        else if (ridx == word_idx(OFF_PLATFORM))      rd_data = C_PLATFORM;
        else if (ridx == word_idx(OFF_BOARD_VERSION)) rd_data = C_BOARD_VERSION;
        else if (ridx == word_idx(OFF_CAPS))          rd_data = CAPS_VAL;
        else if (ridx == word_idx(OFF_IRQ_STATUS))    rd_data = status32;
        else if (ridx == word_idx(OFF_IRQ_ENABLE))    rd_data = enable32;
`ifdef ZZLAB_ENV_UPTIME_EN
        else if (ridx == word_idx(OFF_UPTIME_LO))     rd_data = uptime_q[31:0];
        else if (ridx == word_idx(OFF_UPTIME_HI))     rd_data = uptime_hi_q;
`endif
        else begin
            rd_hit = 1'b0;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (ridx == word_idx(OFF_SCRATCH0 + 4 * i)) begin
                    rd_data = scratch_q[i];
                    rd_hit  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            RDIDLE:  if (ar_fire) rstate_d = RDDATA;
            RDDATA:  if (s_axi_control_RREADY) rstate_d = RDIDLE;
            default: rstate_d = RDIDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rstate_q <= RDIDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rstate_q <= rstate_d;
            if (ar_fire) begin
                rdata_q <= rd_data;
                rresp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_zzlab_env_regs.sv
// Directed bench for zzlab_env_regs: expected read data/responses and write
// responses are queued when a transaction is issued and checked on completion.
module tb_zzlab_env_regs;
    import zzlab_env_pkg::*;

`ifdef ZZLAB_ENV_UPTIME_EN
    localparam logic [31:0] EXP_CAPS = 32'h80000104;
`else
    localparam logic [31:0] EXP_CAPS = 32'h00000104;
`endif

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [7:0]  AWADDR, ARADDR;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic [7:0]  irq_src;
    logic        interrupt;

    int errors = 0;
    int checks = 0;
    logic [33:0] rd_q [$];
    logic [1:0]  b_q  [$];

    always #5 ap_clk = ~ap_clk;

    zzlab_env_regs dut (
        .ap_clk                (ap_clk),
        .ap_rst_n              (ap_rst_n),
        .s_axi_control_AWVALID (AWVALID),
        .s_axi_control_AWREADY (AWREADY),
        .s_axi_control_AWADDR  (AWADDR),
        .s_axi_control_WVALID  (WVALID),
        .s_axi_control_WREADY  (WREADY),
        .s_axi_control_WDATA   (WDATA),
        .s_axi_control_WSTRB   (WSTRB),
        .s_axi_control_BVALID  (BVALID),
        .s_axi_control_BREADY  (BREADY),
        .s_axi_control_BRESP   (BRESP),
        .s_axi_control_ARVALID (ARVALID),
        .s_axi_control_ARREADY (ARREADY),
        .s_axi_control_ARADDR  (ARADDR),
        .s_axi_control_RVALID  (RVALID),
        .s_axi_control_RREADY  (RREADY),
        .s_axi_control_RDATA   (RDATA),
        .s_axi_control_RRESP   (RRESP),
        .irq_src               (irq_src),
        .interrupt             (interrupt)
    );

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic aw_w(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input logic [1:0] exp_resp);
        bit ok;
        b_q.push_back(exp_resp);
        AWADDR = addr; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            ok = AWREADY;
            tick();
            if (ok) break;
        end
        AWVALID = 1'b0;
        if (!ok) chk("aw_timeout", 0, 1);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            ok = WREADY;
            tick();
            if (ok) break;
        end
        WVALID = 1'b0;
        if (!ok) chk("w_timeout", 0, 1);
    endtask

    task automatic b_phase(input string tag);
        bit ok;
        logic [1:0] e;
        ok = 1'b0;
        BREADY = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (BVALID) begin
                e = b_q.pop_front();
                chk(tag, BRESP, e);
                ok = 1'b1;
            end
            tick();
            if (ok) break;
        end
        BREADY = 1'b0;
        if (!ok) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] exp_resp, input string tag);
        aw_w(addr, data, strb, exp_resp);
        b_phase(tag);
    endtask

    task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input string tag);
        bit ok;
        logic [33:0] e;
        rd_q.push_back({exp_resp, exp_data});
        ARADDR = addr; ARVALID = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            ok = ARREADY;
            tick();
            if (ok) break;
        end
        ARVALID = 1'b0;
        if (!ok) chk({tag, "_ar_timeout"}, 0, 1);
        chk({tag, "_lat"}, RVALID, 1);
        RREADY = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (RVALID) begin
                e = rd_q.pop_front();
                chk(tag, {RRESP, RDATA}, e);
                ok = 1'b1;
            end
            tick();
            if (ok) break;
        end
        RREADY = 1'b0;
        if (!ok) chk({tag, "_r_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        ap_rst_n = 1'b0;
        AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
        AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0; irq_src = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_resp", {BRESP, RRESP}, 0);
        chk("rst_irq", interrupt, 0);
        ap_rst_n = 1'b1;
        tick(); tick();

        axi_read(8'h00, 32'h25020401, RESP_OKAY, "rd_version");
        axi_read(8'h04, 32'h5650524F, RESP_OKAY, "rd_platform");
        axi_read(8'h08, 32'h00020101, RESP_OKAY, "rd_board");
        axi_read(8'h0C, EXP_CAPS,     RESP_OKAY, "rd_caps");
        axi_read(8'h07, 32'h5650524F, RESP_OKAY, "rd_lsb_ignored");
`ifndef ZZLAB_ENV_UPTIME_EN
        axi_read(8'h18, 32'h0, RESP_SLVERR, "rd_uptime_lo_unmapped");
        axi_read(8'h1C, 32'h0, RESP_SLVERR, "rd_uptime_hi_unmapped");
`endif

        axi_write(8'h20, 32'hDEADBEEF, 4'b0101, RESP_OKAY, "wr_scr0");
        axi_read(8'h20, 32'h00AD00EF, RESP_OKAY, "rd_scr0_strb");
        axi_read(8'h30, 32'h0, RESP_SLVERR, "rd_unmapped_30");
        axi_write(8'h2C, 32'h12345678, 4'hF, RESP_OKAY, "wr_scr3");
        axi_read(8'h2C, 32'h12345678, RESP_OKAY, "rd_scr3");
        axi_write(8'h40, 32'hFFFFFFFF, 4'hF, RESP_SLVERR, "wr_unmapped");
        axi_write(8'h00, 32'h0, 4'hF, RESP_OKAY, "wr_ro");
        axi_read(8'h00, 32'h25020401, RESP_OKAY, "rd_version_after_ro_wr");

        axi_write(8'h14, 32'h1, 4'hF, RESP_OKAY, "wr_en");
        axi_write(8'h14, 32'hFF, 4'b0000, RESP_OKAY, "wr_en_nostrb");
        axi_read(8'h14, 32'h1, RESP_OKAY, "rd_en");
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        chk("irq_pre", interrupt, 0);
        tick();
        chk("irq_set", interrupt, 1);
        axi_read(8'h10, 32'h1, RESP_OKAY, "rd_status_set");
        aw_w(8'h10, 32'h1, 4'hF, RESP_OKAY);
        chk("irq_hold", interrupt, 1);
        b_phase("wr_w1c");
        chk("irq_clr", interrupt, 0);
        axi_read(8'h10, 32'h0, RESP_OKAY, "rd_status_clr");

        irq_src = 8'h01;
        axi_write(8'h10, 32'h1, 4'hF, RESP_OKAY, "wr_w1c_race");
        irq_src = 8'h00;
        axi_read(8'h10, 32'h1, RESP_OKAY, "rd_set_wins");
        axi_write(8'h10, 32'h1, 4'hF, RESP_OKAY, "wr_w1c_again");
        tick();
        chk("irq_clr2", interrupt, 0);

        irq_src = 8'h02;
        tick();
        irq_src = 8'h00;
        tick(); tick();
        chk("irq_masked", interrupt, 0);
        axi_read(8'h10, 32'h2, RESP_OKAY, "rd_status_masked");
        axi_write(8'h10, 32'hFFFFFFFF, 4'b0000, RESP_OKAY, "wr_w1c_nostrb");
        axi_read(8'h10, 32'h2, RESP_OKAY, "rd_status_kept");
        axi_write(8'h10, 32'h2, 4'b0001, RESP_OKAY, "wr_w1c_b1");
        axi_read(8'h10, 32'h0, RESP_OKAY, "rd_status_zero");

        aw_w(8'h24, 32'hA5A5A5A5, 4'hF, RESP_OKAY);
        AWADDR = 8'h28; AWVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bhold_bvalid", BVALID, 1);
            chk("bhold_bresp", BRESP, RESP_OKAY);
            chk("bhold_awready", AWREADY, 0);
            tick();
        end
        AWVALID = 1'b0;
        b_phase("bhold_b");
        axi_read(8'h24, 32'hA5A5A5A5, RESP_OKAY, "rd_scr1");
        axi_read(8'h28, 32'h0, RESP_OKAY, "rd_scr2_untouched");

`ifdef ZZLAB_ENV_UPTIME_EN
        force dut.uptime_q = 64'h00000000_FFFFFFFF;
        axi_read(8'h18, 32'hFFFFFFFF, RESP_OKAY, "rd_uptime_lo");
        release dut.uptime_q;
        axi_read(8'h1C, 32'h00000000, RESP_OKAY, "rd_uptime_hi_shadow");
`endif

        ARADDR = 8'h00; ARVALID = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            ok = ARREADY;
            tick();
            if (ok) break;
        end
        ARVALID = 1'b0;
        if (!ok) chk("rstrd_ar_timeout", 0, 1);
        chk("rstrd_pending", RVALID, 1);
        ap_rst_n = 1'b0;
        #1;
        chk("rstrd_rvalid", RVALID, 0);
        chk("rstrd_arready", ARREADY, 0);
        chk("rstrd_rdata", RDATA, 0);
        tick();
        ap_rst_n = 1'b1;
        tick(); tick();
        axi_read(8'h20, 32'h0, RESP_OKAY, "rd_scr0_after_rst");
        axi_read(8'h24, 32'h0, RESP_OKAY, "rd_scr1_after_rst");
        axi_read(8'h14, 32'h0, RESP_OKAY, "rd_en_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
